// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
package prbs_pkg;

  localparam int unsigned PRBS_N    = 8;
  localparam logic [7:0]  PRBS_TAPS = 8'hB8;
  localparam logic [7:0]  PER_LAST  = 8'd254;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next LFSR word: shift left, feedback is the parity of the tapped bits.
  function automatic logic [PRBS_N-1:0] lfsr_nxt(input logic [PRBS_N-1:0] w);
    return {w[PRBS_N-2:0], ^(w & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from received data, then flywheels
// its own prediction while locked, counting mismatches and detecting loss.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_cnt,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic          period_done
);

  localparam int unsigned MW = $clog2(LOCK_CNT) + 1;
  localparam int unsigned LW = $clog2(LOSS_CNT) + 1;

  state_e              state_q, state_d;
  logic [PRBS_N-1:0]   exp_q, exp_d;
  logic [MW-1:0]       match_q, match_d;
  logic [LW-1:0]       miss_q, miss_d;
  logic [7:0]          per_q, per_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;
  logic                err_pulse_q, err_pulse_d;
  logic                period_done_q, period_done_d;
  logic                locked_q;
  logic [PRBS_N-1:0]   data_w;

  assign data_w = PRBS_N'(in_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      exp_q         <= '0;
      match_q       <= '0;
      miss_q        <= '0;
      per_q         <= '0;
      err_cnt_q     <= '0;
      err_pulse_q   <= 1'b0;
      period_done_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      per_q         <= per_d;
      err_cnt_q     <= err_cnt_d;
      err_pulse_q   <= err_pulse_d;
      period_done_q <= period_done_d;
      locked_q      <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    match_d       = match_q;
    miss_d        = miss_q;
    per_d         = per_q;
    err_cnt_d     = err_cnt_q;
    err_pulse_d   = 1'b0;
    period_done_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (data_w != '0) begin
            exp_d   = lfsr_nxt(data_w);
            match_d = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (data_w == exp_q) begin
            exp_d = lfsr_nxt(data_w);
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
              per_d   = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (data_w != '0) begin
            exp_d   = lfsr_nxt(data_w);
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never follows the received data here.
          exp_d = lfsr_nxt(exp_q);
          if (per_q == PER_LAST) begin
            per_d         = '0;
            period_done_d = 1'b1;
          end else begin
            per_d = per_q + 8'd1;
          end
          if ((data_w != exp_q) || (data_w == '0)) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
              per_d   = '0;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) err_cnt_d = '0;
  end

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;
  assign period_done = period_done_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side checker for the 8-bit LFSR pseudo-random stream produced by the team's generator. It self-synchronises to an incoming word stream by seeding from received data, then verifies every subsequent word against its own flywheel prediction. It counts errors and flags loss of lock. It sits at the sink of a PRNG link or loopback path, one word per valid cycle.

## Interface
- N, 8, word width; only 8 supported (taps fixed)
- LOCK_CNT, 4, consecutive matches required to declare lock (≥1)
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock (≥1)
- CW, 16, error-counter width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- clear_cnt  input  1  synchronous clear of err_cnt
- in_valid  input  1  in_data valid this cycle
- in_data  input  N  received LFSR word
- locked  output  1  registered; high in LOCKED state
- err_pulse  output  1  registered one-cycle pulse per mismatching word while LOCKED
- err_cnt  output  CW  saturating mismatch count (LOCKED only)
- period_done  output  1  registered one-cycle pulse after 255 consecutive LOCKED words

## Operation
- Next-word function: nxt(w) = {w[6:0], w[7]^w[5]^w[4]^w[3]}; maximal period 255, all-zero excluded.
- States: HUNT (reset), ACQ, LOCKED. Registers: expected[N], match_cnt, miss_cnt, per_cnt (0..254).
- Cycles with in_valid=0 change nothing except clear_cnt; all outputs hold, pulses are 0.
- HUNT, valid word: nonzero → expected<=nxt(in_data), match_cnt<=0, go ACQ; zero → stay HUNT.
- ACQ, valid word == expected: if match_cnt==LOCK_CNT-1 → LOCKED, miss_cnt<=0, per_cnt<=0; else match_cnt+1. expected<=nxt(in_data).
- ACQ, mismatch: nonzero → reseed expected<=nxt(in_data), match_cnt<=0, stay ACQ; zero → HUNT. No err_cnt change.
- LOCKED, any valid word: expected<=nxt(expected) (flywheel; never reseeds from data). per_cnt increments; at 254 it wraps to 0 and period_done pulses.
- LOCKED match: miss_cnt<=0.
- LOCKED mismatch (all-zero word is always a mismatch): err_pulse, err_cnt+1 saturating at 2^CW-1, miss_cnt+1.
- When miss_cnt==LOSS_CNT-1 on a mismatch → HUNT. The error is still counted. locked drops next cycle.
- clear_cnt with a simultaneous error: clear wins (err_cnt=0); err_pulse still asserts.
- Leaving LOCKED clears per_cnt and miss_cnt; err_cnt persists.

## Timing
- Reset values: locked=0, err_pulse=0, err_cnt=0, period_done=0, state HUNT, expected=0, all counters 0.
- Reset mid-operation: outputs zero immediately (asynchronous); first edge after deassertion behaves as HUNT.
- Minimum acquisition: 1 seed word + LOCK_CNT matching words. locked rises at the edge that samples the last matching word.
- err_pulse / period_done: high for the single cycle after the edge sampling the causing word.
- err_cnt reflects the increment in that same cycle.
- Back-to-back valid words supported every cycle; no backpressure.

## Structure
- Package prbs_pkg: N default, tap constant (8'hB8 feedback mask), state enum {HUNT, ACQ, LOCKED}, function lfsr_nxt(w), shared with the generator.
- Single module; no sub-module needed. The next-word logic is the package function, so the generator and checker cannot diverge.

## Test plan
- Lock: reset, feed 0x01,0x02,0x04,0x08,0x11,0x23 on consecutive valid cycles → locked=1 after 0x11 is sampled; err_cnt=0.
- Error: after lock, inject 0x55 in place of one expected word, then resume the correct sequence → single err_pulse, err_cnt=1, locked stays 1.
- Loss: after lock, 3 consecutive wrong words → err_cnt=3, locked=0 the cycle after the third. Next nonzero word reseeds; relock after 4 further matches.
- Zero/gaps: 0x00 words in HUNT are ignored. in_valid gaps inside ACQ/LOCKED → no state or count change.
- Period/saturation: 255 locked words → exactly one period_done. Sustained errors with CW=4 and LOSS_CNT=255 → err_cnt saturates at 15. clear_cnt coinciding with an error → err_cnt=0.
- Async reset asserted mid-LOCKED between edges → locked, err_cnt, pulses go 0 immediately; relock follows the normal sequence.
